// File: rtl/nios2_ocimem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : nios2_ocimem_access_arbiter
// Brief    : Shares the OCI debug RAM between the Avalon debug slave and the
//            JTAG debug path; owns MonAReg (post-increment) and MonDReg.
// Revision : 1.0 - initial release
// ============================================================================
module nios2_ocimem_access_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [37:0]       jdo,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [DATA_W-1:0] av_writedata,
    input  logic              av_debugaccess,
    output logic [DATA_W-1:0] av_readdata,
    output logic              av_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] MonDReg,
    output logic [ADDR_W-1:0] MonAReg,
    output logic              jt_busy,
    output logic              jt_overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        AV_RD = 2'd1,
        JT_RD = 2'd2
    } state_t;

    localparam logic c_GRANT_AV = 1'b0;
    localparam logic c_GRANT_JT = 1'b1;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_last_grant;
    logic                r_jt_pend;
    logic                r_jt_is_wr;
    logic [DATA_W-1:0]   r_jt_wdata;
    logic [ADDR_W-1:0]   r_mon_a;
    logic [DATA_W-1:0]   r_mon_d;
    logic                r_overrun;

    logic                w_av_req;
    logic                w_pick_jt;
    logic                w_pick_av;
    logic                w_jt_wr_done;
    logic                w_jt_rd_done;
    logic                w_jt_pulse;
    logic                w_unused_jdo;

    assign w_av_req     = av_read | av_write;
    assign w_jt_pulse   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign w_unused_jdo = &{1'b0, jdo[37:DATA_W+3], jdo[2:0]};

    // Round-robin on a tie; outputs are held quiet while reset is asserted.
    assign w_pick_jt = reset_n && (r_state == IDLE) && r_jt_pend &&
                       (!w_av_req || (r_last_grant == c_GRANT_AV));
    assign w_pick_av = reset_n && (r_state == IDLE) && w_av_req && !w_pick_jt;

    assign w_jt_wr_done = w_pick_jt && r_jt_is_wr;
    assign w_jt_rd_done = reset_n && (r_state == JT_RD);

    always_comb begin
        w_state_next   = r_state;
        av_readdata    = '0;
        av_waitrequest = 1'b0;
        ram_addr       = '0;
        ram_wren       = 1'b0;
        ram_wdata      = '0;
        if (reset_n) begin
            case (r_state)
                IDLE: begin
                    if (w_pick_jt) begin
                        ram_addr       = r_mon_a;
                        av_waitrequest = w_av_req;
                        if (r_jt_is_wr) begin
                            ram_wren  = 1'b1;
                            ram_wdata = r_jt_wdata;
                        end else begin
                            w_state_next = JT_RD;
                        end
                    end else if (w_pick_av) begin
                        ram_addr = av_address;
                        if (av_write) begin
                            ram_wren       = av_debugaccess;
                            ram_wdata      = av_writedata;
                            av_waitrequest = 1'b0;
                        end else begin
                            av_waitrequest = 1'b1;
                            w_state_next   = AV_RD;
                        end
                    end
                end
                AV_RD: begin
                    av_readdata    = ram_rdata;
                    av_waitrequest = 1'b0;
                    w_state_next   = IDLE;
                end
                JT_RD: begin
                    av_waitrequest = w_av_req;
                    w_state_next   = IDLE;
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_last_grant <= c_GRANT_AV;
        end else begin
            r_state <= w_state_next;
            if (w_pick_jt) begin
                r_last_grant <= c_GRANT_JT;
            end else if (w_pick_av) begin
                r_last_grant <= c_GRANT_AV;
            end
        end
    end

    // A JTAG pulse is only accepted while nothing is pending, so the
    // completion updates below never collide with a capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_jt_pend  <= 1'b0;
            r_jt_is_wr <= 1'b0;
            r_jt_wdata <= '0;
            r_mon_a    <= '0;
            r_mon_d    <= '0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_jt_wr_done) begin
                r_mon_d   <= r_jt_wdata;
                r_mon_a   <= r_mon_a + ADDR_W'(1);
                r_jt_pend <= 1'b0;
            end
            if (w_jt_rd_done) begin
                r_mon_d   <= ram_rdata;
                r_mon_a   <= r_mon_a + ADDR_W'(1);
                r_jt_pend <= 1'b0;
            end
            if (w_jt_pulse) begin
                if (r_jt_pend) begin
                    r_overrun <= 1'b1;
                end else begin
                    if (take_action_ocimem_a) begin
                        r_mon_a <= jdo[ADDR_W+17:18];
                    end
                    if (take_action_ocimem_b || take_no_action_ocimem_a) begin
                        r_jt_pend  <= 1'b1;
                        r_jt_is_wr <= take_action_ocimem_b;
                        r_jt_wdata <= jdo[DATA_W+2:3];
                    end
                end
            end
        end
    end

    assign MonAReg    = r_mon_a;
    assign MonDReg    = r_mon_d;
    assign jt_busy    = r_jt_pend;
    assign jt_overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_nios2_ocimem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios2_ocimem_access_arbiter
// Brief    : Directed bench for the OCI RAM arbiter with a registered RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nios2_ocimem_access_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic [37:0] jdo;
    logic [7:0]  av_address;
    logic        av_read;
    logic        av_write;
    logic [31:0] av_writedata;
    logic        av_debugaccess;
    logic [31:0] av_readdata;
    logic        av_waitrequest;
    logic [7:0]  ram_addr;
    logic        ram_wren;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [31:0] MonDReg;
    logic [7:0]  MonAReg;
    logic        jt_busy;
    logic        jt_overrun;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    nios2_ocimem_access_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .jdo                     (jdo),
        .av_address              (av_address),
        .av_read                 (av_read),
        .av_write                (av_write),
        .av_writedata            (av_writedata),
        .av_debugaccess          (av_debugaccess),
        .av_readdata             (av_readdata),
        .av_waitrequest          (av_waitrequest),
        .ram_addr                (ram_addr),
        .ram_wren                (ram_wren),
        .ram_wdata               (ram_wdata),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (MonDReg),
        .MonAReg                 (MonAReg),
        .jt_busy                 (jt_busy),
        .jt_overrun              (jt_overrun)
    );

    // Single-port RAM with registered read data.
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [37:0] jdo_addr(input logic [7:0] a);
        return {12'b0, a, 18'b0};
    endfunction

    function automatic logic [37:0] jdo_data(input logic [31:0] d);
        return {3'b0, d, 3'b0};
    endfunction

    task automatic clear_pulses;
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        reset_n = 1'b0;
        clear_pulses();
        jdo = '0;
        av_address = 8'h33; av_read = 1'b1; av_write = 1'b0;
        av_writedata = '0; av_debugaccess = 1'b0;
        tick(); tick();

        // Reset values, with an Avalon read pending that must stay masked
        chk("rst_waitreq", 32'(av_waitrequest), 32'h0);
        chk("rst_readdata", av_readdata, 32'h0);
        chk("rst_ram_addr", 32'(ram_addr), 32'h0);
        chk("rst_ram_wren", 32'(ram_wren), 32'h0);
        chk("rst_ram_wdata", ram_wdata, 32'h0);
        chk("rst_MonDReg", MonDReg, 32'h0);
        chk("rst_MonAReg", 32'(MonAReg), 32'h0);
        chk("rst_jt_busy", 32'(jt_busy), 32'h0);
        chk("rst_overrun", 32'(jt_overrun), 32'h0);
        av_read = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        // Uncontested Avalon write, zero wait states
        av_address = 8'h10; av_writedata = 32'hDEADBEEF; av_write = 1'b1; av_debugaccess = 1'b1;
        #1;
        chk("avwr_wren", 32'(ram_wren), 32'h1);
        chk("avwr_addr", 32'(ram_addr), 32'h10);
        chk("avwr_wdata", ram_wdata, 32'hDEADBEEF);
        chk("avwr_waitreq", 32'(av_waitrequest), 32'h0);
        tick();
        av_write = 1'b0;

        // Load MonAReg, then JTAG read with post-increment
        take_action_ocimem_a = 1'b1; jdo = jdo_addr(8'h10);
        tick();
        clear_pulses();
        chk("loada_MonAReg", 32'(MonAReg), 32'h10);
        chk("loada_busy", 32'(jt_busy), 32'h0);
        take_no_action_ocimem_a = 1'b1;
        tick();
        clear_pulses();
        #1;
        chk("jrd_n1_busy", 32'(jt_busy), 32'h1);
        chk("jrd_n1_addr", 32'(ram_addr), 32'h10);
        chk("jrd_n1_wren", 32'(ram_wren), 32'h0);
        tick();
        chk("jrd_n2_busy", 32'(jt_busy), 32'h1);
        chk("jrd_n2_wren", 32'(ram_wren), 32'h0);
        tick();
        chk("jrd_n3_busy", 32'(jt_busy), 32'h0);
        chk("jrd_MonDReg", MonDReg, 32'hDEADBEEF);
        chk("jrd_MonAReg", 32'(MonAReg), 32'h11);

        // Wrap-around on JTAG write at 0xFF
        take_action_ocimem_a = 1'b1; jdo = jdo_addr(8'hFF);
        tick();
        clear_pulses();
        take_action_ocimem_b = 1'b1; jdo = jdo_data(32'h12345678);
        tick();
        clear_pulses();
        #1;
        chk("wrap_addr", 32'(ram_addr), 32'hFF);
        chk("wrap_wren", 32'(ram_wren), 32'h1);
        chk("wrap_wdata", ram_wdata, 32'h12345678);
        chk("wrap_busy", 32'(jt_busy), 32'h1);
        tick();
        chk("wrap_MonAReg", 32'(MonAReg), 32'h00);
        chk("wrap_MonDReg", MonDReg, 32'h12345678);
        chk("wrap_busy_low", 32'(jt_busy), 32'h0);
        av_read = 1'b1; av_address = 8'hFF;
        #1;
        chk("avrd_wait1", 32'(av_waitrequest), 32'h1);
        chk("avrd_addr", 32'(ram_addr), 32'hFF);
        tick();
        chk("avrd_wait0", 32'(av_waitrequest), 32'h0);
        chk("avrd_data", av_readdata, 32'h12345678);
        av_read = 1'b0;
        tick();
        chk("avrd_idle_data", av_readdata, 32'h0);

        // Contention: Avalon read held while JTAG writes keep arriving
        take_action_ocimem_b = 1'b1; jdo = jdo_data(32'h11111111);
        tick();
        clear_pulses();
        av_read = 1'b1; av_address = 8'hFF;
        #1;
        chk("tie1_jt_wren", 32'(ram_wren), 32'h1);
        chk("tie1_jt_addr", 32'(ram_addr), 32'h00);
        chk("tie1_av_wait", 32'(av_waitrequest), 32'h1);
        tick();
        chk("c2_av_addr", 32'(ram_addr), 32'hFF);
        chk("c2_av_wait", 32'(av_waitrequest), 32'h1);
        chk("c2_wren", 32'(ram_wren), 32'h0);
        chk("c2_busy", 32'(jt_busy), 32'h0);
        take_action_ocimem_b = 1'b1; jdo = jdo_data(32'h22222222);
        tick();
        clear_pulses();
        chk("c3_av_wait", 32'(av_waitrequest), 32'h0);
        chk("c3_av_data", av_readdata, 32'h12345678);
        chk("c3_busy", 32'(jt_busy), 32'h1);
        tick();
        chk("tie2_jt_wren", 32'(ram_wren), 32'h1);
        chk("tie2_jt_addr", 32'(ram_addr), 32'h01);
        chk("tie2_jt_wdata", ram_wdata, 32'h22222222);
        chk("tie2_av_wait", 32'(av_waitrequest), 32'h1);
        tick();
        chk("c5_av_addr", 32'(ram_addr), 32'hFF);
        chk("c5_av_wait", 32'(av_waitrequest), 32'h1);
        chk("c5_MonAReg", 32'(MonAReg), 32'h02);
        tick();
        chk("c6_av_data", av_readdata, 32'h12345678);
        av_read = 1'b0;
        tick();

        // Tie after a JTAG grant goes to Avalon
        take_action_ocimem_b = 1'b1; jdo = jdo_data(32'h44444444);
        tick();
        clear_pulses();
        #1;
        chk("m1_jt_addr", 32'(ram_addr), 32'h02);
        tick();
        take_action_ocimem_b = 1'b1; jdo = jdo_data(32'h55555555);
        tick();
        clear_pulses();
        av_read = 1'b1; av_address = 8'h01;
        #1;
        chk("tie3_av_addr", 32'(ram_addr), 32'h01);
        chk("tie3_wren", 32'(ram_wren), 32'h0);
        chk("tie3_av_wait", 32'(av_waitrequest), 32'h1);
        tick();
        chk("m4_av_data", av_readdata, 32'h22222222);
        chk("m4_busy", 32'(jt_busy), 32'h1);
        av_read = 1'b0;
        #1;
        chk("m4_idle_wait", 32'(av_waitrequest), 32'h0);
        tick();
        chk("m5_jt_wren", 32'(ram_wren), 32'h1);
        chk("m5_jt_addr", 32'(ram_addr), 32'h03);
        tick();
        chk("m6_MonAReg", 32'(MonAReg), 32'h04);
        chk("m6_MonDReg", MonDReg, 32'h55555555);

        // Overrun: pulse while busy is dropped
        chk("ovr_before", 32'(jt_overrun), 32'h0);
        take_action_ocimem_b = 1'b1; jdo = jdo_data(32'h66666666);
        tick();
        clear_pulses();
        take_action_ocimem_a = 1'b1; jdo = jdo_addr(8'h80);
        tick();
        clear_pulses();
        chk("ovr_MonAReg", 32'(MonAReg), 32'h05);
        chk("ovr_MonDReg", MonDReg, 32'h66666666);
        chk("ovr_flag", 32'(jt_overrun), 32'h1);
        take_action_ocimem_a = 1'b1; jdo = jdo_addr(8'h40);
        tick();
        clear_pulses();
        chk("ovr_loada", 32'(MonAReg), 32'h40);
        chk("ovr_sticky", 32'(jt_overrun), 32'h1);

        // Write without debugaccess leaves RAM unchanged
        av_address = 8'h10; av_writedata = 32'hCAFEF00D; av_write = 1'b1; av_debugaccess = 1'b0;
        #1;
        chk("nodbg_wait", 32'(av_waitrequest), 32'h0);
        chk("nodbg_wren", 32'(ram_wren), 32'h0);
        tick();
        av_write = 1'b0;
        av_read = 1'b1;
        tick();
        chk("nodbg_rb_wait", 32'(av_waitrequest), 32'h0);
        chk("nodbg_rb_data", av_readdata, 32'hDEADBEEF);
        av_read = 1'b0;
        tick();

        // Reset during AV_RD
        av_read = 1'b1; av_address = 8'h10;
        tick();
        reset_n = 1'b0;
        #1;
        chk("rmid_wait", 32'(av_waitrequest), 32'h0);
        chk("rmid_data", av_readdata, 32'h0);
        chk("rmid_addr", 32'(ram_addr), 32'h0);
        chk("rmid_MonAReg", 32'(MonAReg), 32'h0);
        chk("rmid_overrun", 32'(jt_overrun), 32'h0);
        av_read = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("rpost_addr", 32'(ram_addr), 32'h0);
        chk("rpost_wren", 32'(ram_wren), 32'h0);
        chk("rpost_data", av_readdata, 32'h0);

        // First tie after reset goes to JTAG
        take_action_ocimem_b = 1'b1; jdo = jdo_data(32'h77777777);
        tick();
        clear_pulses();
        av_read = 1'b1;
        #1;
        chk("rtie_wren", 32'(ram_wren), 32'h1);
        chk("rtie_addr", 32'(ram_addr), 32'h00);
        chk("rtie_av_wait", 32'(av_waitrequest), 32'h1);
        tick();
        av_read = 1'b0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
